// File: rtl/argmax_pkg.sv
// Shared types and constants for the argmax classifier: FSM states, default sizes, signed-minimum score.
package argmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int DATA_W_DEF      = 32;

    // Most negative score at the default width; seeds the runner-up tracker.
    localparam logic [DATA_W_DEF-1:0] SCORE_MIN_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-select: the candidate replaces the current best only when strictly greater,
// so ties keep the earlier (lower) index. Zero latency, no flow control.
module argmax_cmp #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic [DATA_W-1:0] i_cand,
    input  logic [IDX_W-1:0]  i_cand_idx,
    input  logic [DATA_W-1:0] i_best,
    input  logic [IDX_W-1:0]  i_best_idx,
    output logic              o_take,
    output logic [DATA_W-1:0] o_best,
    output logic [IDX_W-1:0]  o_best_idx
);

    assign o_take     = $signed(i_cand) > $signed(i_best);
    assign o_best     = o_take ? i_cand : i_best;
    assign o_best_idx = o_take ? i_cand_idx : i_best_idx;

endmodule

// File: rtl/argmax_classifier.sv
// Snapshots NUM_CLASSES scores on an acc_ready rising edge, scans one class per cycle, result valid NUM_CLASSES edges
// after capture and held until class_ack; starts while busy are dropped and flagged in overrun. Optional ARGMAX_MARGIN_EN adds margin.
module argmax_classifier
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          acc_ready,
    input  logic [NUM_CLASSES*DATA_W-1:0] acc_results,
    output logic                          class_valid,
    input  logic                          class_ack,
    output logic [IDX_W-1:0]              class_idx,
    output logic [DATA_W-1:0]             class_score,
    output logic                          busy,
    output logic [CNT_W-1:0]              done_count,
    output logic                          overrun
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0]             margin
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_prev_ready;
    logic [DATA_W-1:0] r_snap [NUM_CLASSES];
    logic [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]  r_best_idx;
    logic [IDX_W-1:0]  r_ptr;
    logic              r_class_valid;
    logic [IDX_W-1:0]  r_class_idx;
    logic [DATA_W-1:0] r_class_score;
    logic [CNT_W-1:0]  r_done_count;
    logic              r_overrun;

    logic              w_start;
    logic              w_last;
    logic [DATA_W-1:0] w_cand;
    logic              w_take;
    logic [DATA_W-1:0] w_new_best;
    logic [IDX_W-1:0]  w_new_idx;

    assign w_start = acc_ready && !r_prev_ready;
    assign w_last  = (r_ptr == IDX_W'(NUM_CLASSES - 1));
    assign w_cand  = r_snap[r_ptr];

    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .i_cand     (w_cand),
        .i_cand_idx (r_ptr),
        .i_best     (r_best),
        .i_best_idx (r_best_idx),
        .o_take     (w_take),
        .o_best     (w_new_best),
        .o_best_idx (w_new_idx)
    );

`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_W-1:0] W_SMIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] W_SMAX = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] r_runner;
    logic [DATA_W-1:0] r_margin;
    logic [DATA_W-1:0] w_runner_nxt;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_margin;

    // A displaced best becomes the runner-up; otherwise the candidate only competes for second place.
    assign w_runner_nxt = w_take ? r_best :
                          ($signed(w_cand) > $signed(r_runner)) ? w_cand : r_runner;
    assign w_diff       = {w_new_best[DATA_W-1], w_new_best} - {w_runner_nxt[DATA_W-1], w_runner_nxt};

    always_comb begin
        w_margin = w_diff[DATA_W-1:0];
        if (w_diff[DATA_W] != w_diff[DATA_W-1]) begin
            w_margin = w_diff[DATA_W] ? W_SMIN : W_SMAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_runner <= W_SMIN;
            r_margin <= '0;
        end else if (r_state == ST_IDLE && w_start) begin
            r_runner <= W_SMIN;
        end else if (r_state == ST_SCAN) begin
            r_runner <= w_runner_nxt;
            if (w_last) begin
                r_margin <= w_margin;
            end
        end
    end

    assign margin = r_margin;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start)   w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (class_ack) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot isolates the scan from the accelerator overwriting its results mid-scan.
    always_ff @(posedge clk) begin
        if (!reset && r_state == ST_IDLE && w_start) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_snap[k] <= acc_results[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_prev_ready  <= 1'b1;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_ptr         <= '0;
            r_class_valid <= 1'b0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_done_count  <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev_ready <= acc_ready;
            if (w_start && r_state != ST_IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_best     <= acc_results[0 +: DATA_W];
                        r_best_idx <= '0;
                        r_ptr      <= IDX_W'(1);
                    end
                end
                ST_SCAN: begin
                    r_best     <= w_new_best;
                    r_best_idx <= w_new_idx;
                    r_ptr      <= r_ptr + IDX_W'(1);
                    if (w_last) begin
                        r_class_idx   <= w_new_idx;
                        r_class_score <= w_new_best;
                        r_class_valid <= 1'b1;
                        r_done_count  <= r_done_count + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (class_ack) begin
                        r_class_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign class_valid = r_class_valid;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign busy        = (r_state == ST_SCAN);
    assign done_count  = r_done_count;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier: expected results come from a reference argmax model pushed to a scoreboard
// at launch and popped when class_valid rises.
module tb_argmax_classifier;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             acc_ready;
    logic [NC*DW-1:0] acc_results;
    logic             class_valid;
    logic             class_ack;
    logic [IW-1:0]    class_idx;
    logic [DW-1:0]    class_score;
    logic             busy;
    logic [CW-1:0]    done_count;
    logic             overrun;
`ifdef ARGMAX_MARGIN_EN
    logic [DW-1:0]    margin;
`endif

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] score;
        logic [DW-1:0] mrg;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            sc[NC];
    logic [CW-1:0] exp_done;

    always #5 clk = ~clk;

    argmax_classifier dut (
        .clk         (clk),
        .reset       (reset),
        .acc_ready   (acc_ready),
        .acc_results (acc_results),
        .class_valid (class_valid),
        .class_ack   (class_ack),
        .class_idx   (class_idx),
        .class_score (class_score),
        .busy        (busy),
        .done_count  (done_count),
        .overrun     (overrun)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin      (margin)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_scores();
        for (int k = 0; k < NC; k++) acc_results[k*DW +: DW] = sc[k];
    endtask

    // Reference: strict-greater signed argmax; runner-up is the largest score outside the winning slot.
    task automatic push_expected();
        exp_t   e;
        int     b;
        int     bi;
        longint r;
        longint m;
        b  = sc[0];
        bi = 0;
        for (int k = 1; k < NC; k++) if (sc[k] > b) begin b = sc[k]; bi = k; end
        r = -64'sd2147483648;
        for (int k = 0; k < NC; k++) if (k != bi && longint'(sc[k]) > r) r = longint'(sc[k]);
        m = longint'(b) - r;
        if (m > 64'sd2147483647) m = 64'sd2147483647;
        e.idx   = IW'(bi);
        e.score = DW'(b);
        e.mrg   = DW'(m);
        sb.push_back(e);
    endtask

    task automatic launch();
        drive_scores();
        push_expected();
        acc_ready = 1'b0;
        @(negedge clk);
        acc_ready = 1'b1;
    endtask

    task automatic collect(input int already);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = 0;
        bcnt = already;
        for (int k = already + 1; k <= 40; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (class_valid) begin
                lat = k;
                break;
            end
        end
        exp_done = exp_done + CW'(1);
        chk("latency", lat, 10);
        chk("busy_cycles", bcnt, 9);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("class_idx", class_idx, e.idx);
            chk("class_score", class_score, e.score);
`ifdef ARGMAX_MARGIN_EN
            chk("margin", margin, e.mrg);
`endif
        end
        chk("done_count", done_count, exp_done);
    endtask

    task automatic ack();
        class_ack = 1'b1;
        @(negedge clk);
        class_ack = 1'b0;
        chk("valid_after_ack", class_valid, 0);
        chk("busy_after_ack", busy, 0);
    endtask

    task automatic run_scan();
        launch();
        collect(0);
        ack();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_done = '0;
    endtask

    initial begin
        logic [IW-1:0] h_idx;
        logic [DW-1:0] h_score;
        int            bad;

        reset       = 1'b1;
        acc_ready   = 1'b0;
        class_ack   = 1'b0;
        acc_results = '0;
        exp_done    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid", class_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_score", class_score, 0);
        chk("rst_done", done_count, 0);

        // Basic pattern: winner is class 2 with 12.
        sc = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
        run_scan();
        chk("basic_idx_const", class_idx, 2);
        chk("basic_score_const", class_score, 12);

        // Signed compare: all negative, class 7 least negative.
        for (int k = 0; k < NC; k++) sc[k] = -100;
        sc[7] = -1;
        run_scan();
        chk("signed_idx_const", class_idx, 7);

        // Tie keeps the lowest index.
        for (int k = 0; k < NC; k++) sc[k] = 0;
        sc[3] = 50;
        sc[8] = 50;
        run_scan();
        chk("tie_idx_const", class_idx, 3);

        // Restart mid-scan with new results plus a stray ack: snapshot must win, overrun set.
        chk("overrun_pre", overrun, 0);
        sc = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
        launch();
        @(negedge clk);
        class_ack = 1'b1;
        @(negedge clk);
        class_ack = 1'b0;
        acc_ready = 1'b0;
        @(negedge clk);
        sc = '{99, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        drive_scores();
        acc_ready = 1'b1;
        collect(3);
        chk("overrun_set", overrun, 1);
        ack();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (class_valid || busy) bad++;
        end
        chk("no_second_scan", bad, 0);
        chk("done_after_overrun", done_count, exp_done);
        chk("overrun_sticky", overrun, 1);

        // Reset on the 4th scan cycle aborts; level-high ready afterwards is not a start.
        sc = '{0, 0, 0, 0, 0, 0, 77, 0, 0, 0};
        drive_scores();
        acc_ready = 1'b0;
        @(negedge clk);
        acc_ready = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        chk("abort_valid", class_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_overrun", overrun, 0);
        chk("abort_idx", class_idx, 0);
        chk("abort_score", class_score, 0);
        chk("abort_done", done_count, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (class_valid || busy) bad++;
        end
        chk("no_start_on_level", bad, 0);
        run_scan();
        chk("post_abort_idx", class_idx, 6);

        // 256 classifications from a clean count: counter wraps to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < NC; k++) begin
                if (i[0]) sc[k] = int'($urandom_range(0, 7)) - 4;
                else      sc[k] = int'($urandom);
            end
            run_scan();
        end
        chk("done_wrap", done_count, 0);

        // Without ack the result is held.
        sc = '{-7, 3, 3, 9, -20, 8, 9, 1, 0, 2};
        launch();
        collect(0);
        h_idx   = class_idx;
        h_score = class_score;
        bad     = 0;
        repeat (50) begin
            @(negedge clk);
            if (!class_valid || class_idx !== h_idx || class_score !== h_score || busy) bad++;
        end
        chk("hold_stable", bad, 0);
        ack();
        chk("idx_kept_after_ack", class_idx, 3);

`ifdef ARGMAX_MARGIN_EN
        sc = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 11};
        run_scan();
        chk("margin_const", margin, 32'd1);
        for (int k = 0; k < NC; k++) sc[k] = 32'h8000_0000;
        sc[0] = 32'h7FFF_FFFF;
        run_scan();
        chk("margin_sat_const", margin, 32'h7FFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
